// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the Balotelli memory stage: bus widths, access-size
// encodings, FSM state encodings and small address helpers.
package mem_access_unit_pkg;

    localparam int DataWidth        = 64;
    localparam int RegFileAddrWidth = 5;
    localparam int ByteOffsetWidth  = 3;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2,
        MEM_SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    // Unshifted byte-lane mask for an access of the given size.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (mem_size_e'(size))
            MEM_SIZE_B: mask = 8'h01;
            MEM_SIZE_H: mask = 8'h03;
            MEM_SIZE_W: mask = 8'h0F;
            MEM_SIZE_D: mask = 8'hFF;
            default:    mask = 8'h00;
        endcase
        return mask;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [ByteOffsetWidth-1:0] offset);
        logic bad;
        case (mem_size_e'(size))
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = offset[0];
            MEM_SIZE_W: bad = |offset[1:0];
            MEM_SIZE_D: bad = |offset[2:0];
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: selects the addressed bytes from an 8-byte-aligned bus
// word, masks them to the access size and sign- or zero-extends the result.
// Purely combinational so a cache refill path can reuse it.
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DataWidth
) (
    input  logic [DATA_WIDTH-1:0]      load_word,
    input  logic [ByteOffsetWidth-1:0] offset,
    input  logic [1:0]                 size,
    input  logic                       is_unsigned,
    output logic [DATA_WIDTH-1:0]      result
);

    logic [DATA_WIDTH-1:0] shifted_s;

    // Shift the addressed byte to lane 0, then mask and extend by size.
    // Bytes beyond the top of the word shift in as zero, which truncates
    // accesses that straddle the 8-byte boundary.
    always_comb begin
        shifted_s = load_word >> {offset, 3'b000};
        result    = shifted_s;
        case (mem_size_e'(size))
            MEM_SIZE_B: result = {{(DATA_WIDTH-8){shifted_s[7] & ~is_unsigned}},
                                  shifted_s[7:0]};
            MEM_SIZE_H: result = {{(DATA_WIDTH-16){shifted_s[15] & ~is_unsigned}},
                                  shifted_s[15:0]};
            MEM_SIZE_W: result = {{(DATA_WIDTH-32){shifted_s[31] & ~is_unsigned}},
                                  shifted_s[31:0]};
            MEM_SIZE_D: result = shifted_s;
            default:    result = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of the Balotelli pipeline. Consumes the EX->MEM register,
// issues data-bus requests over a valid/ready handshake, aligns load data and
// produces the rd write-back triple for the MEM->WB register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// (adds the MisalignOut port); otherwise boundary-crossing bytes are dropped.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = DataWidth,
    parameter int ADDR_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = RegFileAddrWidth
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      InValid,
    input  logic [DATA_WIDTH-1:0]     RdWriteDataIn,
    input  logic [REG_ADDR_WIDTH-1:0] RdAddrIn,
    input  logic                      RdWriteEnableIn,
    input  logic                      MemReadIn,
    input  logic                      MemWriteIn,
    input  logic [1:0]                MemSizeIn,
    input  logic                      MemUnsignedIn,
    input  logic [DATA_WIDTH-1:0]     StoreDataIn,
    output logic                      StallReq,
    output logic                      DReqValid,
    input  logic                      DReqReady,
    output logic [ADDR_WIDTH-1:0]     DReqAddr,
    output logic                      DReqWrite,
    output logic [DATA_WIDTH-1:0]     DReqWData,
    output logic [DATA_WIDTH/8-1:0]   DReqStrb,
    input  logic                      DRespValid,
    input  logic [DATA_WIDTH-1:0]     DRespData,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      MisalignOut,
`endif
    output logic                      OutValid,
    output logic [DATA_WIDTH-1:0]     RdWriteDataOut,
    output logic [REG_ADDR_WIDTH-1:0] RdAddrOut,
    output logic                      RdWriteEnableOut
);

    localparam int StrbWidth = DATA_WIDTH / 8;

    mau_state_e                 state_r;

    // Latched access context
    logic [ByteOffsetWidth-1:0] offset_r;
    logic [1:0]                 size_r;
    logic                       unsigned_r;
    logic [REG_ADDR_WIDTH-1:0]  rd_r;
    logic                       we_r;

    // Bus request registers
    logic                       req_valid_r;
    logic [ADDR_WIDTH-1:0]      req_addr_r;
    logic                       req_write_r;
    logic [DATA_WIDTH-1:0]      req_wdata_r;
    logic [StrbWidth-1:0]       req_strb_r;

    // Write-back registers
    logic                       out_valid_r;
    logic [DATA_WIDTH-1:0]      out_data_r;
    logic [REG_ADDR_WIDTH-1:0]  out_rd_r;
    logic                       out_we_r;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                       misalign_r;
`endif

    // Combinational helpers
    logic                       mem_op_s;
    logic                       misalign_s;
    logic                       issue_s;
    logic                       stall_s;
    logic [ADDR_WIDTH-1:0]      addr_in_s;
    logic [ByteOffsetWidth-1:0] offset_in_s;
    logic [DATA_WIDTH-1:0]      store_masked_s;
    logic [DATA_WIDTH-1:0]      wdata_s;
    logic [StrbWidth-1:0]       strb_s;
    logic [DATA_WIDTH-1:0]      load_result_s;

    assign addr_in_s   = ADDR_WIDTH'(RdWriteDataIn);
    assign offset_in_s = addr_in_s[ByteOffsetWidth-1:0];
    assign mem_op_s    = InValid & (MemReadIn | MemWriteIn);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s  = is_misaligned(MemSizeIn, offset_in_s);
`else
    assign misalign_s  = 1'b0;
`endif

    assign issue_s = (state_r == ST_IDLE) & mem_op_s & ~misalign_s;

    // Right-justified store data masked to the access size and moved to its
    // byte lane; lanes past the top of the word fall off.
    always_comb begin
        store_masked_s = StoreDataIn;
        case (mem_size_e'(MemSizeIn))
            MEM_SIZE_B: store_masked_s = DATA_WIDTH'(StoreDataIn[7:0]);
            MEM_SIZE_H: store_masked_s = DATA_WIDTH'(StoreDataIn[15:0]);
            MEM_SIZE_W: store_masked_s = DATA_WIDTH'(StoreDataIn[31:0]);
            MEM_SIZE_D: store_masked_s = StoreDataIn;
            default:    store_masked_s = StoreDataIn;
        endcase
        wdata_s = store_masked_s << {offset_in_s, 3'b000};
        strb_s  = StrbWidth'(size_byte_mask(MemSizeIn)) << offset_in_s;
    end

    // Stall from the issue cycle until the cycle that completes the access,
    // so the EX->MEM register advances exactly on the completing edge.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = issue_s;
            ST_REQ:  stall_s = ~(DReqReady & req_write_r);
            ST_RESP: stall_s = ~DRespValid;
            default: stall_s = 1'b0;
        endcase
    end

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .load_word   (DRespData),
        .offset      (offset_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .result      (load_result_s)
    );

    // Access FSM with registered bus request and write-back triple.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            offset_r    <= '0;
            size_r      <= 2'd0;
            unsigned_r  <= 1'b0;
            rd_r        <= '0;
            we_r        <= 1'b0;
            req_valid_r <= 1'b0;
            req_addr_r  <= '0;
            req_write_r <= 1'b0;
            req_wdata_r <= '0;
            req_strb_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_rd_r    <= '0;
            out_we_r    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_r  <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            out_we_r    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_r  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (InValid && !(MemReadIn || MemWriteIn)) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= RdWriteDataIn;
                        out_rd_r    <= RdAddrIn;
                        out_we_r    <= RdWriteEnableIn;
                    end else if (issue_s) begin
                        offset_r    <= offset_in_s;
                        size_r      <= MemSizeIn;
                        unsigned_r  <= MemUnsignedIn;
                        rd_r        <= RdAddrIn;
                        we_r        <= RdWriteEnableIn;
                        req_valid_r <= 1'b1;
                        req_addr_r  <= {addr_in_s[ADDR_WIDTH-1:ByteOffsetWidth],
                                        {ByteOffsetWidth{1'b0}}};
                        req_write_r <= MemWriteIn;
                        req_wdata_r <= wdata_s;
                        req_strb_r  <= strb_s;
                        state_r     <= ST_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
                    end else if (mem_op_s) begin
                        // Misaligned: report the faulting address, no bus access.
                        out_valid_r <= 1'b1;
                        out_data_r  <= RdWriteDataIn;
                        out_rd_r    <= RdAddrIn;
                        misalign_r  <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (DReqReady) begin
                        req_valid_r <= 1'b0;
                        if (req_write_r) begin
                            out_valid_r <= 1'b1;
                            out_rd_r    <= rd_r;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (DRespValid) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= load_result_s;
                        out_rd_r    <= rd_r;
                        out_we_r    <= we_r;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    req_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign StallReq         = stall_s;
    assign DReqValid        = req_valid_r;
    assign DReqAddr         = req_addr_r;
    assign DReqWrite        = req_write_r;
    assign DReqWData        = req_wdata_r;
    assign DReqStrb         = req_strb_r;
    assign OutValid         = out_valid_r;
    assign RdWriteDataOut   = out_data_r;
    assign RdAddrOut        = out_rd_r;
    assign RdWriteEnableOut = out_we_r;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MisalignOut      = misalign_r;
`endif

endmodule
